// File: rtl/rom_image_loader_if.sv
// rom_image_loader_if: byte-stream input and ROM BRAM write-port bundle.
//   din[7:0]          stream byte (source -> loader)
//   din_valid         din holds a valid byte (source -> loader)
//   din_ready         loader accepts din this cycle (loader -> source)
//   mem_we            BRAM write enable, one cycle per byte (loader -> BRAM)
//   mem_a[ADDR_W-1:0] BRAM write address (loader -> BRAM)
//   mem_d[7:0]        BRAM write data (loader -> BRAM)
// master: source/BRAM side; slave: the loader.
interface rom_image_loader_if #(parameter int ADDR_W = 15);
    logic [7:0]        din;
    logic              din_valid;
    logic              din_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_d;
    modport master (output din, din_valid, input din_ready, mem_we, mem_a, mem_d);
    modport slave  (input din, din_valid, output din_ready, mem_we, mem_a, mem_d);
endinterface

// File: rtl/rom_image_loader.sv
// rom_image_loader: copies a byte stream into the ROM BRAM and holds the Z80 in reset until done.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse, (re)load from address 0 (ignored while loading)
//   bus        stream input and BRAM write port (rom_image_loader_if.slave)
//   busy       load in progress
//   done       image fully written, sticky until next load or reset
//   checksum   modulo-256 sum of bytes accepted in the current load
//   cpu_rst_n  Z80 reset, low until done
module rom_image_loader #(
    parameter int ADDR_W     = 15,
    parameter int IMG_SIZE   = 32768,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    rom_image_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum,
    output logic              cpu_rst_n
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_SIZE - 1);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              hs, enter, ready_nx, busy_nx, done_nx;
    // din_ready is only ever high in LOAD, so a handshake implies LOAD
    assign hs    = bus.din_valid & bus.din_ready;
    assign enter = (state_nx == LOAD) && (state != LOAD);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.din_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_rst_n     <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.din_ready <= ready_nx;
            busy          <= busy_nx;
            done          <= done_nx;
            cpu_rst_n     <= done_nx;
        end
    end
    // IDLE is only reachable through reset, so with AUTO_START it always launches a load
    always_comb begin
        state_nx = state == IDLE  ? ((start || AUTO_START) ? LOAD : IDLE) :
                   state == LOAD  ? ((hs && cnt == LAST) ? FLUSH : LOAD) :
                   state == FLUSH ? DONE :
                                    (start ? LOAD : DONE);
    end
    // status outputs are registered copies of the upcoming state
    always_comb begin
        ready_nx = state_nx == LOAD;
        busy_nx  = state_nx == LOAD || state_nx == FLUSH;
        done_nx  = state_nx == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_a  <= '0;
            bus.mem_d  <= 8'h00;
            checksum   <= 8'h00;
        end else begin
            bus.mem_we <= hs;
            if (enter) begin
                cnt       <= '0;
                bus.mem_a <= '0;
                checksum  <= 8'h00;
            end else if (hs) begin
                cnt       <= cnt + 1'b1;
                bus.mem_a <= cnt;
                bus.mem_d <= bus.din;
                checksum  <= checksum + bus.din;
            end
        end
    end
endmodule

// File: tb/tb_rom_image_loader.sv
// tb_rom_image_loader: four loader configurations checked every cycle against a phase/byte-count model.
module tb_rom_image_loader;
    localparam int SZ_T [4] = '{16, 16, 1, 32768};
    localparam bit AU_T [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        clk = 1'b0;
    logic [3:0]  rst_n, st, dv, rdy, we, busy, done, crst, hp, sp, rp;
    logic [7:0]  din [4];
    logic [7:0]  md [4];
    logic [7:0]  cs [4];
    logic [7:0]  bp [4];
    logic [7:0]  sum [4];
    logic [7:0]  lb [4];
    logic [14:0] ma [4];
    int          ph [4];
    int          acc [4];
    int          nw [4];
    int          vec = 0, bad = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_u
        rom_image_loader_if #(.ADDR_W(15)) bus ();
        assign bus.din       = din[g];
        assign bus.din_valid = dv[g];
        assign rdy[g]        = bus.din_ready;
        assign we[g]         = bus.mem_we;
        assign ma[g]         = bus.mem_a;
        assign md[g]         = bus.mem_d;
        rom_image_loader #(.ADDR_W(15), .IMG_SIZE(SZ_T[g]), .AUTO_START(AU_T[g])) u_dut (
            .clk(clk), .rst_n(rst_n[g]), .start(st[g]), .bus(bus),
            .busy(busy[g]), .done(done[g]), .checksum(cs[g]), .cpu_rst_n(crst[g])
        );
    end
    task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s u%0d @%0t: got %0h want %0h", tag, i, $time, got, exp);
        end
    endtask
    // values seen by the DUT at each rising edge
    always @(posedge clk) begin
        hp <= dv & rdy;
        sp <= st;
        rp <= rst_n;
        bp <= din;
    end
    // model phases: 0 idle, 1 loading, 3 last write on the bus, 2 done
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) nw[i]++;
            if (!rst_n[i]) begin
                ph[i] = 0;
                acc[i] = 0;
                sum[i] = 8'h00;
                chk("rst_ctl", i, {27'd0, we[i], busy[i], done[i], crst[i], rdy[i]}, 32'd0);
                chk("rst_bus", i, {1'b0, ma[i], md[i], cs[i]}, 32'd0);
            end else begin
                if ((ph[i] == 0 && rp[i] && (sp[i] || AU_T[i])) || (ph[i] == 2 && sp[i])) begin
                    ph[i] = 1;
                    acc[i] = 0;
                    sum[i] = 8'h00;
                end else if (ph[i] == 3) ph[i] = 2;
                chk("mem_we", i, 32'(we[i]), 32'(hp[i]));
                if (hp[i]) begin
                    chk("mem_a", i, 32'(ma[i]), acc[i]);
                    chk("mem_d", i, 32'(md[i]), 32'(bp[i]));
                    sum[i] += bp[i];
                    lb[i] = bp[i];
                    acc[i]++;
                    if (acc[i] == SZ_T[i]) ph[i] = 3;
                end else if (ph[i] != 0 && acc[i] > 0) begin
                    chk("hold_a", i, 32'(ma[i]), acc[i] - 1);
                    chk("hold_d", i, 32'(md[i]), 32'(lb[i]));
                end else if (ph[i] == 1) chk("start_a", i, 32'(ma[i]), 32'd0);
                chk("busy", i, 32'(busy[i]), 32'(ph[i] == 1 || ph[i] == 3));
                chk("done", i, 32'(done[i]), 32'(ph[i] == 2));
                chk("cpu_rst_n", i, 32'(crst[i]), 32'(ph[i] == 2));
                chk("din_ready", i, 32'(rdy[i]), 32'(ph[i] == 1));
                chk("checksum", i, 32'(cs[i]), 32'(sum[i]));
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic pulse(input int i);
        @(posedge clk); #1 st[i] = 1'b1;
        @(posedge clk); #1 st[i] = 1'b0;
    endtask
    // pat: 0..255 constant byte, 256 byte index, 257 random; vm: 0 held, 1 toggling, 2 random
    task automatic stream(input int i, input int n, input int pat, input int vm);
        int k = 0;
        for (int t = 0; k < n && t < 4 * n + 20; t++) begin
            @(posedge clk); #1;
            dv[i] = vm == 0 ? 1'b1 : vm == 1 ? ~t[0] : 1'($urandom_range(0, 1));
            din[i] = pat == 256 ? 8'(k) : pat == 257 ? 8'($urandom) : 8'(pat);
            if (dv[i] && rdy[i]) k++;
        end
        @(posedge clk); #1;
        dv[i] = 1'b0;
        chk("accepted", i, k, n);
    endtask
    initial begin
        rst_n = '0;
        st = '0;
        dv = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        idle(3);
        rst_n = '1;
        stream(0, 16, 256, 0);
        idle(3);
        chk("cs_inc", 0, 32'(cs[0]), 32'h78);
        chk("released", 0, 32'(done[0] & crst[0]), 32'd1);
        chk("writes", 0, nw[0], 32'd16);
        pulse(0);
        stream(0, 16, 256, 1);
        idle(3);
        chk("cs_toggle", 0, 32'(cs[0]), 32'h78);
        chk("writes", 0, nw[0], 32'd32);
        pulse(0);
        stream(0, 16, 257, 2);
        idle(3);
        chk("released", 0, 32'(done[0]), 32'd1);
        pulse(0);
        stream(0, 5, 256, 0);
        @(posedge clk); #1 rst_n[0] = 1'b0;
        idle(2);
        rst_n[0] = 1'b1;
        stream(0, 16, 8'hA5, 0);
        idle(3);
        chk("cs_a5", 0, 32'(cs[0]), 32'h50);
        chk("released", 0, 32'(done[0] & crst[0]), 32'd1);
        chk("no_auto", 1, nw[1], 32'd0);
        pulse(1);
        fork
            stream(1, 16, 257, 2);
            begin
                idle(6);
                pulse(1);
            end
        join
        idle(3);
        chk("released", 1, 32'(done[1]), 32'd1);
        pulse(1);
        stream(1, 16, 257, 0);
        idle(3);
        chk("writes", 1, nw[1], 32'd32);
        chk("released", 1, 32'(done[1] & crst[1]), 32'd1);
        pulse(2);
        stream(2, 1, 8'h3C, 0);
        idle(3);
        chk("cs_one", 2, 32'(cs[2]), 32'h3C);
        chk("writes", 2, nw[2], 32'd1);
        chk("released", 2, 32'(done[2] & crst[2]), 32'd1);
        stream(3, 32768, 8'hFF, 0);
        idle(3);
        chk("cs_full", 3, 32'(cs[3]), 32'h00);
        chk("writes", 3, nw[3], 32'd32768);
        chk("last_a", 3, 32'(ma[3]), 32'h7FFF);
        chk("released", 3, 32'(done[3] & crst[3]), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
